// File: rtl/io_pkg.sv
// Shared types and widths for the IN/OUT sequencer.
// The optional debouncer is selected by the IO_DEBOUNCE_EN macro (see io_debouncer).
package io_pkg;

  localparam int DATA_W = 32;
  localparam int SW_W   = 10;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    WAIT_PRESS   = 2'd1,
    WAIT_RELEASE = 2'd2,
    DONE         = 2'd3
  } io_state_t;

  function automatic logic [DATA_W-1:0] zext_sw(input logic [SW_W-1:0] s);
    return {{(DATA_W-SW_W){1'b0}}, s};
  endfunction

endpackage

// File: rtl/io_sequencer_if.sv
// Core-side I/O handshake between the decode stage (master) and the sequencer (slave).
interface io_sequencer_if;
  import io_pkg::*;

  logic              io_req;
  logic              io_sel;
  logic [DATA_W-1:0] wr_data;
  logic [DATA_W-1:0] rd_data;
  logic              stall;
  logic              io_done;

  modport master (output io_req, io_sel, wr_data, input rd_data, stall, io_done);
  modport slave  (input io_req, io_sel, wr_data, output rd_data, stall, io_done);

endinterface

// File: rtl/io_debouncer.sv
// Enter-key input path: 2-flop synchronizer, then a counter debouncer when
// IO_DEBOUNCE_EN is defined; otherwise the synchronized level is used directly.
module io_debouncer #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_key_n,
  output logic o_level,
  output logic o_rise
);

  if (DEBOUNCE_CYCLES < 1) begin : g_bad_cfg
    $error("io_debouncer: DEBOUNCE_CYCLES must be at least 1");
  end

  logic r_sync1;
  logic r_sync2;

  // Synchronizer resets to the released (high) level of the active-low key.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= i_key_n;
      r_sync2 <= r_sync1;
    end
  end

`ifdef IO_DEBOUNCE_EN
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_level;
  logic             w_pressed;
  logic             w_flip;

  assign w_pressed = ~r_sync2;
  assign w_flip    = (w_pressed != r_level) && (r_cnt == CNT_LAST);

  // Count consecutive disagreeing cycles; any agreement restarts the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_level <= 1'b0;
    end else if (w_pressed == r_level) begin
      r_cnt <= '0;
    end else if (w_flip) begin
      r_cnt   <= '0;
      r_level <= w_pressed;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_level = r_level;
  assign o_rise  = w_flip & w_pressed;
`else
  // Rise is flagged one stage early so capture lands on the edge the level rises.
  assign o_level = ~r_sync2;
  assign o_rise  = ~r_sync1 & r_sync2;
`endif

endmodule

// File: rtl/io_sequencer.sv
// IN/OUT instruction sequencer: OUT latches the display word, IN stalls until a
// debounced enter press/release. Debouncing is controlled by IO_DEBOUNCE_EN.
module io_sequencer
  import io_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic              clk,
  input  logic              rst_n,
  io_sequencer_if.slave     bus,
  input  logic [SW_W-1:0]   sw,
  input  logic              key_n,
  output logic [DATA_W-1:0] disp_value,
  output logic              waiting
);

  io_state_t         r_state;
  logic [DATA_W-1:0] r_disp;
  logic [DATA_W-1:0] r_rd;
  logic              r_done;
  logic              r_waiting;
  logic              w_level;
  logic              w_rise;

  io_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_key_n (key_n),
    .o_level (w_level),
    .o_rise  (w_rise)
  );

  // Sequencer FSM; io_done and waiting are registered alongside the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_disp    <= '0;
      r_rd      <= '0;
      r_done    <= 1'b0;
      r_waiting <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.io_req) begin
            if (bus.io_sel) begin
              r_state   <= WAIT_PRESS;
              r_waiting <= 1'b1;
            end else begin
              r_disp  <= bus.wr_data;
              r_state <= DONE;
              r_done  <= 1'b1;
            end
          end
        end
        WAIT_PRESS: begin
          // Only a fresh press edge counts; a key held on entry never rises here.
          if (!bus.io_req) begin
            r_state   <= IDLE;
            r_waiting <= 1'b0;
          end else if (w_rise) begin
            r_rd      <= zext_sw(sw);
            r_state   <= WAIT_RELEASE;
            r_waiting <= 1'b0;
          end
        end
        WAIT_RELEASE: begin
          if (!bus.io_req) begin
            r_state <= IDLE;
          end else if (!w_level) begin
            r_state <= DONE;
            r_done  <= 1'b1;
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state   <= IDLE;
          r_waiting <= 1'b0;
        end
      endcase
    end
  end

  // Stall must assert in the request cycle itself, hence combinational.
  assign bus.stall   = ((r_state == IDLE) && bus.io_req) ||
                       (r_state == WAIT_PRESS) || (r_state == WAIT_RELEASE);
  assign bus.io_done = r_done;
  assign bus.rd_data = r_rd;
  assign disp_value  = r_disp;
  assign waiting     = r_waiting;

endmodule

// File: tb/tb_io_sequencer.sv
// Directed self-checking bench for io_sequencer; expectations adapt to IO_DEBOUNCE_EN.
module tb_io_sequencer;
  import io_pkg::*;

  localparam int DB = 4;
`ifdef IO_DEBOUNCE_EN
  localparam int PL = 2 + DB;
`else
  localparam int PL = 2;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [SW_W-1:0]   sw = 10'h000;
  logic              key_n = 1'b1;
  logic [DATA_W-1:0] disp_value;
  logic              waiting;
  int                errors = 0;
  int                checks = 0;

  io_sequencer_if bus ();

  io_sequencer #(.DEBOUNCE_CYCLES(DB)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .sw         (sw),
    .key_n      (key_n),
    .disp_value (disp_value),
    .waiting    (waiting)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  initial begin
    bus.io_req  = 1'b0;
    bus.io_sel  = 1'b0;
    bus.wr_data = 32'h0;

    // Reset state
    #12;
    chk("rst_disp", disp_value, 32'h0);
    chk("rst_rd", bus.rd_data, 32'h0);
    chk("rst_done", {31'b0, bus.io_done}, 32'h0);
    chk("rst_wait", {31'b0, waiting}, 32'h0);
    chk("rst_stall", {31'b0, bus.stall}, 32'h0);
    rst_n = 1'b1;
    tick;

    // OUT single cycle
    bus.wr_data = 32'h0000_1234; bus.io_sel = 1'b0; bus.io_req = 1'b1;
    #1 chk("out_stall_req", {31'b0, bus.stall}, 32'h1);
    tick;
    bus.io_req = 1'b0;
    chk("out_disp", disp_value, 32'h0000_1234);
    chk("out_done", {31'b0, bus.io_done}, 32'h1);
    chk("out_stall_done", {31'b0, bus.stall}, 32'h0);
    tick;
    chk("out_done_clr", {31'b0, bus.io_done}, 32'h0);
    chk("out_disp_hold", disp_value, 32'h0000_1234);

    // IN with a 10-cycle press
    sw = 10'h2A5; bus.io_sel = 1'b1; bus.io_req = 1'b1;
    #1 chk("in_stall_req", {31'b0, bus.stall}, 32'h1);
    tick;
    chk("in_wait", {31'b0, waiting}, 32'h1);
    key_n = 1'b0;
    repeat (PL - 1) tick;
    chk("in_wait_pending", {31'b0, waiting}, 32'h1);
    chk("in_stall_pending", {31'b0, bus.stall}, 32'h1);
    tick;
    chk("in_wait_accepted", {31'b0, waiting}, 32'h0);
    chk("in_rd", bus.rd_data, 32'h0000_02A5);
    chk("in_stall_held", {31'b0, bus.stall}, 32'h1);
    sw = 10'h3FF;
    for (int i = 0; i < 10 - PL; i++) begin
      tick;
      chk("in_no_done_held", {31'b0, bus.io_done}, 32'h0);
    end
    key_n = 1'b1;
    for (int i = 0; i < PL; i++) begin
      tick;
      chk("in_no_done_rel", {31'b0, bus.io_done}, 32'h0);
      chk("in_stall_rel", {31'b0, bus.stall}, 32'h1);
    end
    tick;
    chk("in_done", {31'b0, bus.io_done}, 32'h1);
    chk("in_rd_kept", bus.rd_data, 32'h0000_02A5);
    chk("in_stall_done", {31'b0, bus.stall}, 32'h0);
    bus.io_req = 1'b0;
    tick;
    chk("in_done_once", {31'b0, bus.io_done}, 32'h0);

    // Key already held when the IN arrives
    key_n = 1'b0;
    repeat (PL + 2) tick;
    sw = 10'h155; bus.io_sel = 1'b1; bus.io_req = 1'b1;
    tick;
    chk("held_wait", {31'b0, waiting}, 32'h1);
    repeat (PL + 3) tick;
    chk("held_ignored", {31'b0, waiting}, 32'h1);
    chk("held_rd", bus.rd_data, 32'h0000_02A5);
    key_n = 1'b1;
    repeat (PL + 2) tick;
    chk("held_released_wait", {31'b0, waiting}, 32'h1);
    key_n = 1'b0;
    repeat (PL) tick;
    chk("repress_wait", {31'b0, waiting}, 32'h0);
    chk("repress_rd", bus.rd_data, 32'h0000_0155);
    key_n = 1'b1;
    repeat (PL + 1) tick;
    chk("repress_done", {31'b0, bus.io_done}, 32'h1);
    bus.io_req = 1'b0;
    tick;

    // 2-cycle glitch during WAIT_PRESS, then abort
    sw = 10'h0F0; bus.io_sel = 1'b1; bus.io_req = 1'b1;
    tick;
    key_n = 1'b0;
    tick;
    tick;
    key_n = 1'b1;
`ifdef IO_DEBOUNCE_EN
    repeat (8) tick;
    chk("glitch_wait", {31'b0, waiting}, 32'h1);
    chk("glitch_rd", bus.rd_data, 32'h0000_0155);
`else
    chk("glitch_wait", {31'b0, waiting}, 32'h0);
    chk("glitch_rd", bus.rd_data, 32'h0000_00F0);
`endif
    bus.io_req = 1'b0;
    tick;
    chk("abort_wait", {31'b0, waiting}, 32'h0);
    chk("abort_done", {31'b0, bus.io_done}, 32'h0);
    chk("abort_stall", {31'b0, bus.stall}, 32'h0);
`ifdef IO_DEBOUNCE_EN
    chk("abort_rd", bus.rd_data, 32'h0000_0155);
`else
    chk("abort_rd", bus.rd_data, 32'h0000_00F0);
`endif
    repeat (PL + 2) tick;

    // Asynchronous reset in WAIT_RELEASE
    sw = 10'h3C3; bus.io_sel = 1'b1; bus.io_req = 1'b1;
    tick;
    key_n = 1'b0;
    repeat (PL) tick;
    chk("wr_rd", bus.rd_data, 32'h0000_03C3);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_rd", bus.rd_data, 32'h0);
    chk("arst_wait", {31'b0, waiting}, 32'h0);
    chk("arst_done", {31'b0, bus.io_done}, 32'h0);
    chk("arst_stall_idle", {31'b0, bus.stall}, 32'h1);
    bus.io_req = 1'b0;
    key_n = 1'b1;
    tick;
    rst_n = 1'b1;
    for (int i = 0; i < PL + 2; i++) begin
      tick;
      chk("arst_no_done", {31'b0, bus.io_done}, 32'h0);
    end

    // Back-to-back OUT requests
    bus.wr_data = 32'hA5A5_0001; bus.io_sel = 1'b0; bus.io_req = 1'b1;
    tick;
    chk("b2b_disp1", disp_value, 32'hA5A5_0001);
    chk("b2b_done1", {31'b0, bus.io_done}, 32'h1);
    bus.wr_data = 32'h0000_BEEF;
    tick;
    chk("b2b_idle_done", {31'b0, bus.io_done}, 32'h0);
    chk("b2b_idle_stall", {31'b0, bus.stall}, 32'h1);
    tick;
    chk("b2b_disp2", disp_value, 32'h0000_BEEF);
    chk("b2b_done2", {31'b0, bus.io_done}, 32'h1);
    bus.io_req = 1'b0;
    tick;
    chk("b2b_end_done", {31'b0, bus.io_done}, 32'h0);
    chk("b2b_disp_hold", disp_value, 32'h0000_BEEF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
